// File: rtl/bigint_pkg.sv
// Shared types and defaults for the word-serial big-integer datapath.
package bigint_pkg;
   localparam int K_DEF = 128;
   localparam int N_DEF = 32;
   localparam int CNT_W = $clog2(N_DEF);

   typedef enum logic {MODE_SUB = 1'b0, MODE_ADD = 1'b1} addsub_mode_e;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;
endpackage

// File: rtl/bigint_word_addsub.sv
// Combinational K-bit add/subtract cell; cout_o is carry (add) or borrow (sub).
module bigint_word_addsub
   import bigint_pkg::*;
#(
   parameter int K = K_DEF
) (
   input  logic [K-1:0]  a_i,
   input  logic [K-1:0]  b_i,
   input  logic          cin_i,
   input  addsub_mode_e  mode_i,
   output logic [K-1:0]  res_o,
   output logic          cout_o
);
   logic [K:0] ext;

   // One extra bit catches carry out; on subtract it wraps high exactly when a < b + cin.
   always_comb begin
      if (mode_i == MODE_ADD) ext = {1'b0, a_i} + {1'b0, b_i} + {{K{1'b0}}, cin_i};
      else                    ext = {1'b0, a_i} - {1'b0, b_i} - {{K{1'b0}}, cin_i};
   end

   assign res_o  = ext[K-1:0];
   assign cout_o = ext[K];
endmodule

// File: rtl/bigint_stream_addsub.sv
// Adds/subtracts a K-bit operand to/from an N-word LSW-first stream with carry ripple across words.
module bigint_stream_addsub
   import bigint_pkg::*;
#(
   parameter int K = K_DEF,
   parameter int N = N_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          task_start,
   input  logic          op_mode,
   input  logic [K-1:0]  op_val,
   input  logic [K-1:0]  in_word,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [K-1:0]  out_word,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic          out_cb,
   output logic          busy
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          carry_q, carry_d;
   addsub_mode_e  mode_q, mode_d;
   logic [K-1:0]  opval_q, opval_d;
   logic [K-1:0]  out_word_q, out_word_d;
   logic          out_valid_q, out_valid_d;
   logic          out_last_q, out_last_d;
   logic          out_cb_q, out_cb_d;
   logic          busy_q, busy_d;

   logic          first_word, last_word;
   logic [K-1:0]  cell_b, cell_res;
   logic          cell_cin, cell_cout;

   // Word 0 takes the operand; later words only take the rippled carry/borrow.
   assign first_word = (cnt_q == '0);
   assign last_word  = (cnt_q == CW'(N - 1));
   assign cell_b     = first_word ? opval_q : '0;
   assign cell_cin   = first_word ? 1'b0 : carry_q;

   bigint_word_addsub #(.K(K)) u_cell (
      .a_i    (in_word),
      .b_i    (cell_b),
      .cin_i  (cell_cin),
      .mode_i (mode_q),
      .res_o  (cell_res),
      .cout_o (cell_cout)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      mode_d      = mode_q;
      opval_d     = opval_q;
      out_word_d  = out_word_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_cb_d    = out_cb_q;
      busy_d      = busy_q;
      in_ready    = 1'b0;

      // Downstream handshake frees the output register; a same-cycle accept below refills it.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
         out_cb_d    = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (task_start) begin
               mode_d  = addsub_mode_e'(op_mode);
               opval_d = op_val;
               cnt_d   = '0;
               carry_d = 1'b0;
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            in_ready = !out_valid_q || out_ready;
            if (in_valid && in_ready) begin
               out_word_d  = cell_res;
               out_valid_d = 1'b1;
               out_last_d  = last_word;
               out_cb_d    = last_word & cell_cout;
               carry_d     = cell_cout;
               cnt_d       = cnt_q + CW'(1);
               if (last_word) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (out_valid_q && out_ready && out_last_q) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         mode_q      <= MODE_SUB;
         opval_q     <= '0;
         out_word_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_cb_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         mode_q      <= mode_d;
         opval_q     <= opval_d;
         out_word_q  <= out_word_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_cb_q    <= out_cb_d;
         busy_q      <= busy_d;
      end
   end

   assign out_word  = out_word_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_cb    = out_cb_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_bigint_stream_addsub.sv
// Random and directed stream operations against a whole-integer arithmetic reference.
module tb_bigint_stream_addsub;
   localparam int K = 128;
   localparam int N = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          task_start = 1'b0;
   logic          op_mode = 1'b0;
   logic [K-1:0]  op_val = '0;
   logic [K-1:0]  in_word = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [K-1:0]  out_word;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;
   logic          out_cb;
   logic          busy;

   int checks = 0;
   int fails  = 0;

   logic [K-1:0] stim [N];
   logic [K-1:0] expw [N];
   logic         exp_cb;

   always #5 clk = ~clk;

   bigint_stream_addsub #(.K(K), .N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .task_start (task_start),
      .op_mode    (op_mode),
      .op_val     (op_val),
      .in_word    (in_word),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_word   (out_word),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .out_cb     (out_cb),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Treat the stream as one K*N-bit integer; bit K*N of the wide result is the carry/borrow.
   task automatic model(input bit mode, input logic [K-1:0] v);
      logic [K*N-1:0] x;
      logic [K*N:0]   r;
      for (int i = 0; i < N; i++) x[i*K +: K] = stim[i];
      if (mode) r = {1'b0, x} + {{(K*N-K+1){1'b0}}, v};
      else      r = {1'b0, x} - {{(K*N-K+1){1'b0}}, v};
      for (int i = 0; i < N; i++) expw[i] = r[i*K +: K];
      exp_cb = r[K*N];
   endtask

   function automatic logic [K-1:0] rnd_word();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         default: return {$urandom, $urandom, $urandom, $urandom};
      endcase
   endfunction

   task automatic check_reset_outputs();
      chk1("rst_out_valid", out_valid, 1'b0);
      chk ("rst_out_word", out_word, '0);
      chk1("rst_out_last", out_last, 1'b0);
      chk1("rst_out_cb", out_cb, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b0);
   endtask

   // abort_at >= 0 pulls reset once that many input words have been accepted.
   task automatic run_op(input bit mode, input logic [K-1:0] v, input bit bp, input int abort_at);
      int ii, oi, cyc;
      logic held_v, held_l, in_hs, out_hs;
      logic [K-1:0] held_w;
      model(mode, v);
      @(negedge clk);
      task_start = 1'b1; op_mode = mode; op_val = v;
      @(negedge clk);
      task_start = 1'b0; op_mode = ~mode; op_val = ~v;
      #1 chk1("busy_after_start", busy, 1'b1);
      ii = 0; oi = 0; cyc = 0; held_v = 1'b0; held_l = 1'b0; held_w = '0;
      while (oi < N && cyc < 3000) begin
         in_valid   = (ii < N) && (!bp || $urandom_range(0, 3) != 0);
         in_word    = (ii < N) ? stim[ii] : '0;
         out_ready  = !bp || ($urandom_range(0, 1) != 0);
         task_start = (cyc == 3) || (oi == N - 1);
         op_val     = {$urandom, $urandom, $urandom, $urandom};
         #1;
         if (abort_at >= 0 && ii == abort_at) begin
            rst_n = 1'b0; in_valid = 1'b0; task_start = 1'b0;
            #1 check_reset_outputs();
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (held_v) begin
            chk1("stall_valid", out_valid, 1'b1);
            chk ("stall_word", out_word, held_w);
            chk1("stall_last", out_last, held_l);
         end
         if (out_valid && !out_ready) chk1("stall_in_ready", in_ready, 1'b0);
         in_hs  = in_valid && in_ready;
         out_hs = out_valid && out_ready;
         if (out_hs) begin
            chk ("out_word", out_word, expw[oi]);
            chk1("out_last", out_last, oi == N - 1);
            if (oi == N - 1) chk1("out_cb", out_cb, exp_cb);
         end
         held_v = out_valid && !out_ready;
         held_w = out_word;
         held_l = out_last;
         @(posedge clk);
         if (in_hs)  ii++;
         if (out_hs) oi++;
         cyc++;
         @(negedge clk);
      end
      chk1("all_words_delivered", oi == N, 1'b1);
      task_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_out_valid", out_valid, 1'b0);
      chk1("idle_in_ready", in_ready, 1'b0);
   endtask

   initial begin
      #2 check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // Decrement of 1
      for (int i = 0; i < N; i++) stim[i] = '0;
      stim[0] = 1;
      run_op(1'b0, 1, 1'b0, -1);

      // Borrow ripple into word 1
      for (int i = 0; i < N; i++) stim[i] = '0;
      stim[1] = 5;
      run_op(1'b0, 1, 1'b0, -1);

      // Full underflow
      for (int i = 0; i < N; i++) stim[i] = '0;
      run_op(1'b0, 1, 1'b1, -1);

      // Add carry ripple through 31 all-ones words
      for (int i = 0; i < N; i++) stim[i] = '1;
      stim[N-1] = '0;
      run_op(1'b1, 1, 1'b0, -1);

      // Full overflow on add
      for (int i = 0; i < N; i++) stim[i] = '1;
      run_op(1'b1, 1, 1'b1, -1);

      // Zero operand passes through
      for (int i = 0; i < N; i++) stim[i] = rnd_word();
      run_op(1'b0, '0, 1'b1, -1);

      // Random operations under backpressure
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < N; i++) stim[i] = rnd_word();
         run_op(1'($urandom_range(0, 1)), rnd_word(), 1'b1, -1);
      end

      // Abort at word 10, then a fresh operation from word 0
      for (int i = 0; i < N; i++) stim[i] = rnd_word();
      run_op(1'b0, rnd_word(), 1'b1, 10);
      for (int i = 0; i < N; i++) stim[i] = rnd_word();
      run_op(1'b1, rnd_word(), 1'b1, -1);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule

// File: doc/bigint_stream_addsub.md
Name: bigint_stream_addsub

Overview:
- Word-serial big-integer add/subtract of a K-bit operand to/from an N-word stream, least-significant word first, with full carry/borrow propagation across all words.
- Successor to the decrement front end of the L-function datapath (L(x) = (x-1)/n).
- Generalised from fixed "-1" to ±operand, with valid/ready backpressure, a last-word marker and a final carry/borrow flag.
- Sits between the modular exponentiation output stream and the divide-by-n stage.

Parameters:
- K, 128, word width in bits.
- N, 32, words per big integer; N ≥ 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- task_start  in  1  one-cycle pulse; arms a new operation (honoured only in IDLE)
- op_mode  in  1  sampled with task_start; 0 = subtract, 1 = add
- op_val  in  K  operand; sampled with task_start; applied to word 0 only
- in_word  in  K  input stream word
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts in_word this cycle
- out_word  out  K  result word
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts out_word
- out_last  out  1  qualifies the final (N-1th) result word
- out_cb  out  1  final carry (add) / borrow (sub); meaningful only with out_valid & out_last
- busy  out  1  high from task_start acceptance until the last word is accepted downstream

Behaviour:
- Reset, as decided: rst_n is asynchronous and active-low; the clock is clk. On reset:
  - state = IDLE; word counter = 0; internal carry = 0.
  - out_word = 0, out_valid = 0, out_last = 0, out_cb = 0, busy = 0.
  - op_val and op_mode registers = 0.
- States:
  - IDLE:
    - in_ready = 0; input words are not consumed.
    - On task_start: latch op_val and op_mode, clear counter and carry, go to RUN, set busy.
  - RUN:
    - in_ready = !out_valid | out_ready (single-entry output register).
    - Accept = in_valid & in_ready.
    - On accept of word i:
      - i = 0: out_word = in_word ± op_val.
      - i > 0: out_word = in_word ± carry.
      - carry ← carry/borrow out of bit K-1, computed in K+1-bit arithmetic.
      - counter += 1.
    - On accept of word N-1: set out_last and out_cb = final carry/borrow, go to DRAIN.
    - task_start is ignored in RUN.
  - DRAIN:
    - in_ready = 0.
    - When out_valid & out_ready & out_last: clear busy and go to IDLE.
    - A task_start in the same cycle as that handshake is ignored; the next cycle in IDLE is the earliest a new start is honoured.
- Latency: out_valid rises 1 cycle after input accept. With out_ready held high, throughput is 1 word/cycle.
- Output hold: while out_valid & !out_ready, out_word/out_last/out_cb remain stable. out_valid drops only after the handshake, unless a new word is accepted in that same cycle.
- Borrow semantics:
  - Subtract: borrow out = (in_word < subtrahend incl. borrow in).
  - Zero words keep propagating the borrow, e.g. 0 - 1 = all-ones with borrow 1.
- Underflow/overflow is not an error: the result wraps modulo 2^(K·N) and is reported on out_cb.
- op_val = 0 passes the stream through unchanged, with out_cb = 0.
- Reset mid-operation: the operation is aborted immediately and all outputs return to reset values. Partially delivered words are not retracted.

Decomposition:
- Shared package bigint_pkg:
  - default K and N, and the derived counter width CNT_W = $clog2(N).
  - enum addsub_mode_e {MODE_SUB = 0, MODE_ADD = 1}.
  - state enum {ST_IDLE, ST_RUN, ST_DRAIN}.
- One natural sub-module: bigint_word_addsub, a combinational K-bit add/sub cell with carry-in, mode and carry-out. It is reused by the later divide stage.

Test Plan:
- Decrement of 1: mode = sub, op_val = 1, stream word0 = 1, others 0 -> all output words 0, out_cb = 0, out_last on word 31.
- Borrow ripple: sub 1 from word0 = 0, word1 = 5, rest 0 -> word0 = {K{1}}, word1 = 4, rest 0, out_cb = 0.
- Full underflow: sub 1 from all-zero input -> every word = {K{1}}, out_cb = 1.
- Add carry ripple: add 1 to all-ones words 0..30, word31 = 0 -> words 0..30 = 0, word31 = 1, out_cb = 0.
- Backpressure: out_ready toggled 1-0-0-1 randomly -> no word lost or duplicated, out_word stable while stalled, in_ready low whenever out_valid & !out_ready.
- Reset at word 10 of a RUN, then task_start -> outputs zero during reset; the new operation is computed correctly from word 0. A task_start issued during RUN is ignored.
